md5_match_detector: RTL and testbench
=====================================

# md5_match_detector

Downstream stage of the MD5 pipeline core: every cycle it takes the 128-bit digest and the 512-bit padded block leaving the core, and compares the digest against a host-loaded target. On the first match it latches the originating candidate message and length and stops. It also counts compared digests, handles pipeline warm-up after a start, and reports exhaustion when a host-set budget runs out.

## Interface
- PIPE_LATENCY, 66: cycles from a candidate entering the core to its digest appearing at `hash` (input register, 64 rounds, output register).
- CNT_W, 48: width of the compared-digest counter.
- clk  in  1  single clock; everything is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  pulse; loads `target`, clears results, begins warm-up; accepted in any state.
- abort  in  1  pulse; returns to IDLE and keeps the result outputs.
- target  in  128  digest to search for, {a,b,c,d} order as produced by the core.
- max_count  in  CNT_W  digest budget, sampled at start; 0 means unlimited.
- hash  in  128  digest from the core.
- msg_in  in  512  padded block from the core: message left-justified, then a single 1 bit, with the length in bits [63:0].
- busy  out  1  high in WARMUP or SCAN.
- found  out  1  sticky match flag.
- exhausted  out  1  sticky flag: budget spent with no match.
- match_msg  out  64  recovered candidate, right-justified.
- match_len  out  7  candidate length in bits (1..64).
- hash_count  out  CNT_W  number of digests compared since the last start.

## Operation
- States: IDLE, WARMUP, SCAN, FOUND, EXHAUSTED.
- IDLE → WARMUP on `start`.
  - On the same edge: `target` and `max_count` are registered; `found`, `exhausted`, `hash_count`, `match_msg` and `match_len` are cleared; the warm-up counter is set to PIPE_LATENCY-1.
- WARMUP: the counter decrements each cycle and `hash` is ignored. When the counter reaches 0, the state moves to SCAN. WARMUP lasts exactly PIPE_LATENCY cycles.
- SCAN, every cycle:
  - `hash_count` increments (saturating at all-ones).
  - If `hash == target`: move to FOUND, set `found`, and capture the candidate.
    - match_len = msg_in[6:0].
    - match_msg = msg_in[511:448] >> (64 - match_len).
  - Otherwise, if max_count ≠ 0 and the incremented count equals max_count: move to EXHAUSTED and set `exhausted`.
- Match and budget end in the same cycle: FOUND wins, and `exhausted` stays 0.
- FOUND and EXHAUSTED are terminal. They leave only on `start` (→ WARMUP) or `abort` (→ IDLE).
- `start` in WARMUP or SCAN restarts exactly as from IDLE.
- `abort` in any state goes to IDLE. `found`, `exhausted`, `match_*` and `hash_count` hold their values.
- `start` and `abort` together: `start` wins.
- msg_in[6:0] of 0 is treated as 64 (shift of 0).

## Timing
- Reset (asynchronous, active-low): state IDLE, all outputs 0, internal target/budget/counter registers 0.
- `busy` rises the cycle after `start` and stays high PIPE_LATENCY cycles (WARMUP) plus the SCAN duration.
- The first digest compared is the one present PIPE_LATENCY cycles after the `start` edge. This corresponds to the upstream candidate presented in the `start` cycle.
- `found` and `match_*` are registered: valid one cycle after the matching `hash`/`msg_in` is present. `busy` falls on that same edge.
- `hash_count` on the edge that sets `found` includes the matching digest. The matching candidate index is hash_count-1.
- There is no backpressure. The core output is consumed every cycle with no stall.
- Reset asserted mid-scan: outputs clear immediately. After release the block stays in IDLE until `start`.

## Test plan
- Reset: drive rst_n=0 mid-SCAN → `busy`, `found`, `exhausted` and `hash_count` all go to 0 asynchronously, and the block is IDLE after release.
- Warm-up masking: target=128'h0123…cdef, start, drive `hash`=target during the first 66 cycles → no `found`, and `hash_count`=0 at the end of WARMUP.
- Match capture:
  - Stimulus: after warm-up, drive 9 non-matching digests, then `hash`=target with msg_in = {24'h616263, 1'b1, zeros, 64'd24}.
  - Required response next cycle: found=1, match_msg=64'h616263, match_len=24, hash_count=10, busy=0.
- Exhaustion: max_count=5, no match → exhausted=1 after the 5th compare, hash_count=5, found=0.
- Simultaneous: max_count=3, and the 3rd digest matches → found=1, exhausted=0.
- Restart and abort:
  - `start` during SCAN → counters clear and a fresh 66-cycle warm-up runs.
  - `abort` after FOUND → IDLE with match_msg held.

Source files
------------

// File: rtl/md5_match_detector.sv
// Match detector behind the MD5 pipeline core: compares every digest against a
// host target, latches the first matching candidate, and enforces a digest budget.
module md5_match_detector #(
   parameter int PIPE_LATENCY = 66,
   parameter int CNT_W        = 48
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [127:0]     target,
   input  logic [CNT_W-1:0] max_count,
   input  logic [127:0]     hash,
   input  logic [511:0]     msg_in,
   output logic             busy,
   output logic             found,
   output logic             exhausted,
   output logic [63:0]      match_msg,
   output logic [6:0]       match_len,
   output logic [CNT_W-1:0] hash_count
);

   localparam int WARM_W = $clog2(PIPE_LATENCY);
   localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(PIPE_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WARMUP,
      S_SCAN,
      S_FOUND,
      S_EXHAUSTED
   } state_e;

   state_e            state_q, state_d;
   logic [127:0]      target_q, target_d;
   logic [CNT_W-1:0]  max_q, max_d;
   logic [WARM_W-1:0] warm_q, warm_d;
   logic              busy_q, busy_d;
   logic              found_q, found_d;
   logic              exhausted_q, exhausted_d;
   logic [63:0]       match_msg_q, match_msg_d;
   logic [6:0]        match_len_q, match_len_d;
   logic [CNT_W-1:0]  hash_count_q, hash_count_d;

   logic [CNT_W-1:0]  cnt_inc;
   logic [6:0]        len_eff;
   logic [6:0]        shamt;
   logic              unused_msg_bits;

   // Only the top 64 message bits and the low length bits matter: candidates are at most 64 bits.
   assign unused_msg_bits = ^msg_in[447:7];

   always_comb begin
      // NOTE: every _d starts from its _q so no branch can leave a latch behind.
      state_d      = state_q;
      target_d     = target_q;
      max_d        = max_q;
      warm_d       = warm_q;
      found_d      = found_q;
      exhausted_d  = exhausted_q;
      match_msg_d  = match_msg_q;
      match_len_d  = match_len_q;
      hash_count_d = hash_count_q;

      cnt_inc = (&hash_count_q) ? hash_count_q : hash_count_q + CNT_W'(1);
      len_eff = (msg_in[6:0] == 7'd0) ? 7'd64 : msg_in[6:0];
      shamt   = 7'd64 - len_eff;

      if (start) begin
         state_d      = S_WARMUP;
         target_d     = target;
         max_d        = max_count;
         warm_d       = WARM_INIT;
         found_d      = 1'b0;
         exhausted_d  = 1'b0;
         match_msg_d  = '0;
         match_len_d  = '0;
         hash_count_d = '0;
      end else if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_WARMUP: begin
               if (warm_q == '0) state_d = S_SCAN;
               else              warm_d  = warm_q - WARM_W'(1);
            end
            S_SCAN: begin
               hash_count_d = cnt_inc;
               // A match takes priority over a budget that runs out on the same digest.
               if (hash == target_q) begin
                  state_d     = S_FOUND;
                  found_d     = 1'b1;
                  match_len_d = len_eff;
                  match_msg_d = msg_in[511:448] >> shamt;
               end else if ((max_q != '0) && (cnt_inc == max_q)) begin
                  state_d     = S_EXHAUSTED;
                  exhausted_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d == S_WARMUP) || (state_d == S_SCAN);
   end

   // NOTE: state is updated with non-blocking assignments only; all registers,
   // including the target and budget, clear on reset since there is no memory here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         target_q     <= '0;
         max_q        <= '0;
         warm_q       <= '0;
         busy_q       <= 1'b0;
         found_q      <= 1'b0;
         exhausted_q  <= 1'b0;
         match_msg_q  <= '0;
         match_len_q  <= '0;
         hash_count_q <= '0;
      end else begin
         state_q      <= state_d;
         target_q     <= target_d;
         max_q        <= max_d;
         warm_q       <= warm_d;
         busy_q       <= busy_d;
         found_q      <= found_d;
         exhausted_q  <= exhausted_d;
         match_msg_q  <= match_msg_d;
         match_len_q  <= match_len_d;
         hash_count_q <= hash_count_d;
      end
   end

   assign busy       = busy_q;
   assign found      = found_q;
   assign exhausted  = exhausted_q;
   assign match_msg  = match_msg_q;
   assign match_len  = match_len_q;
   assign hash_count = hash_count_q;

endmodule

// File: tb/tb_md5_match_detector.sv
// Bench for md5_match_detector: table of match vectors checked through a
// scoreboard queue, plus hand sequences for warm-up, budget, restart, abort and reset.
module tb_md5_match_detector;

   localparam int PL    = 66;
   localparam int CNT_W = 48;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic [127:0]     target;
   logic [CNT_W-1:0] max_count;
   logic [127:0]     hash;
   logic [511:0]     msg_in;
   logic             busy;
   logic             found;
   logic             exhausted;
   logic [63:0]      match_msg;
   logic [6:0]       match_len;
   logic [CNT_W-1:0] hash_count;

   md5_match_detector #(.PIPE_LATENCY(PL), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .target     (target),
      .max_count  (max_count),
      .hash       (hash),
      .msg_in     (msg_in),
      .busy       (busy),
      .found      (found),
      .exhausted  (exhausted),
      .match_msg  (match_msg),
      .match_len  (match_len),
      .hash_count (hash_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] tgt;
      logic [63:0]  msg;
      int           len;
      int           pre;
   } vec_t;

   typedef struct {
      logic [63:0]      msg;
      logic [6:0]       len;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Padded block as the core emits it: message left-justified, a 1 bit, length in [63:0].
   function automatic logic [511:0] build_block(input logic [63:0] msg, input int len);
      logic [511:0] b;
      b             = '0;
      b[511:448]    = msg << (64 - len);
      b[511 - len]  = 1'b1;
      b[63:0]       = 64'(len);
      return b;
   endfunction

   // Called at a negedge; returns at the negedge where the first SCAN compare is driven.
   task automatic do_start(input logic [127:0] tgt, input logic [CNT_W-1:0] maxc,
                           input bit hash_is_target);
      target    = tgt;
      max_count = maxc;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      target    = ~tgt;
      max_count = '0;
      check("busy_rise", busy, 1);
      check("start_clears_count", hash_count, 0);
      check("start_clears_found", found, 0);
      check("start_clears_exh", exhausted, 0);
      repeat (PL) begin
         hash   = hash_is_target ? tgt : ~tgt;
         msg_in = build_block(64'h1, 1);
         @(negedge clk);
      end
      check("warmup_no_found", found, 0);
      check("warmup_count_zero", hash_count, 0);
      check("warmup_busy", busy, 1);
   endtask

   task automatic scan(input logic [127:0] h, input logic [511:0] m);
      hash   = h;
      msg_in = m;
      @(negedge clk);
   endtask

   task automatic expect_found(input string name);
      exp_t e;
      bit   seen;
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
         if (found) seen = 1'b1;
         else       @(negedge clk);
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: actual found=0 required found=1", name);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_sb_empty: actual 0 entries required 1", name);
      end else begin
         e = sb_q.pop_front();
         check({name, "_found"}, found, 1);
         check({name, "_msg"}, match_msg, e.msg);
         check({name, "_len"}, match_len, e.len);
         check({name, "_count"}, hash_count, e.cnt);
         check({name, "_busy"}, busy, 0);
         check({name, "_exh"}, exhausted, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vecs[4];
      logic [127:0] t;
      logic [127:0] t2;
      logic [511:0] blk;

      vecs[0] = '{128'h0123456789abcdef0123456789abcdef, 64'h616263, 24, 9};
      vecs[1] = '{128'hfedcba98765432100f1e2d3c4b5a6978, 64'hdeadbeefcafef00d, 64, 0};
      vecs[2] = '{128'h00000000000000000000000000000001, 64'h1, 1, 3};
      vecs[3] = '{128'h8000000000000000a5a5a5a55a5a5a5a, 64'h55, 7, 2};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      target = '0; max_count = '0; hash = '0; msg_in = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_found", found, 0);
      check("rst_exh", exhausted, 0);
      check("rst_msg", match_msg, 0);
      check("rst_len", match_len, 0);
      check("rst_count", hash_count, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Match vectors; the first one also drives hash==target throughout warm-up.
      for (int i = 0; i < 4; i++) begin
         do_start(vecs[i].tgt, '0, i == 0);
         for (int j = 0; j < vecs[i].pre; j++)
            scan(vecs[i].tgt ^ (128'h1 << (j * 13)), build_block(64'h3, 2));
         sb_q.push_back('{vecs[i].msg, 7'(vecs[i].len), CNT_W'(vecs[i].pre + 1)});
         scan(vecs[i].tgt, build_block(vecs[i].msg, vecs[i].len));
         expect_found($sformatf("vec%0d", i));
         scan(vecs[i].tgt, build_block(64'h3, 2));
         check("found_terminal_count", hash_count, vecs[i].pre + 1);
      end

      // Length field of 0 means a full 64-bit candidate with no shift.
      t = 128'h13579bdf02468ace13579bdf02468ace;
      do_start(t, '0, 0);
      blk = '0;
      blk[511:448] = 64'ha5a50000_12345678;
      scan(t, blk);
      check("len0_found", found, 1);
      check("len0_msg", match_msg, 64'ha5a50000_12345678);

      // Budget of 5 with no match.
      do_start(t, 48'd5, 0);
      for (int j = 0; j < 5; j++) begin
         scan(~t, build_block(64'h3, 2));
         if (j == 3) begin
            check("exh_not_yet", exhausted, 0);
            check("exh_count4", hash_count, 4);
         end
      end
      check("exh_set", exhausted, 1);
      check("exh_count", hash_count, 5);
      check("exh_no_found", found, 0);
      check("exh_busy", busy, 0);
      scan(t, build_block(64'h3, 2));
      check("exh_terminal_found", found, 0);
      check("exh_terminal_count", hash_count, 5);

      // Match on the digest that also spends the budget.
      do_start(t, 48'd3, 0);
      scan(~t, build_block(64'h3, 2));
      scan(~t, build_block(64'h3, 2));
      sb_q.push_back('{64'hab, 7'd8, CNT_W'(3)});
      scan(t, build_block(64'hab, 8));
      expect_found("simul");

      // Restart during SCAN, warm-up masked, then match.
      do_start(t, '0, 0);
      for (int j = 0; j < 4; j++) scan(~t, build_block(64'h3, 2));
      check("pre_restart_count", hash_count, 4);
      t2 = 128'h0badc0de0badc0de0badc0de0badc0de;
      do_start(t2, '0, 1);
      scan(~t2, build_block(64'h3, 2));
      scan(~t2, build_block(64'h3, 2));
      sb_q.push_back('{64'h1234, 7'd16, CNT_W'(3)});
      scan(t2, build_block(64'h1234, 16));
      expect_found("restart");

      // Abort after FOUND keeps results; IDLE does not scan.
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_found_held", found, 1);
      check("abort_msg_held", match_msg, 64'h1234);
      check("abort_len_held", match_len, 16);
      repeat (3) scan(t2, build_block(64'h3, 2));
      check("idle_count_held", hash_count, 3);
      check("idle_busy", busy, 0);

      // start and abort together: start wins.
      target = t2; max_count = '0; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start_wins_busy", busy, 1);
      check("start_wins_found", found, 0);
      // Abort during WARMUP: back to IDLE, no compares afterwards.
      repeat (10) scan(t2, build_block(64'h3, 2));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_warm_busy", busy, 0);
      repeat (PL + 4) scan(t2, build_block(64'h3, 2));
      check("abort_warm_found", found, 0);
      check("abort_warm_count", hash_count, 0);

      // Asynchronous reset mid-SCAN.
      do_start(t, '0, 0);
      for (int j = 0; j < 3; j++) scan(~t, build_block(64'h3, 2));
      check("pre_rst_count", hash_count, 3);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_found", found, 0);
      check("arst_exh", exhausted, 0);
      check("arst_count", hash_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) scan(t, build_block(64'h3, 2));
      check("post_rst_busy", busy, 0);
      check("post_rst_found", found, 0);
      check("post_rst_count", hash_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
